// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: fetch PC, icache read port, branch-predictor redirection and a DEPTH-entry fetch queue.
// Optional FETCH_QUEUE_BYPASS_EN: an empty queue hands a fresh response straight to decode in the same cycle.
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter int          META_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     icache_read,
  output logic [31:0]              icache_addr,
  input  logic [31:0]              icache_rdata,
  input  logic                     icache_resp,
  input  logic                     bp_br_en,
  input  logic                     btb_hit,
  input  logic [31:0]              bp_target,
  input  logic [META_W-1:0]        bp_meta,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_pc,
  output logic [31:0]              deq_instr,
  output logic                     deq_pred_taken,
  output logic [31:0]              deq_pred_target,
  output logic [META_W-1:0]        deq_meta,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              taken;
    logic [31:0]       target;
    logic [META_W-1:0] meta;
  } entry_t;

  typedef enum logic [1:0] {RUN, FULL, KILL} state_t;

  state_t        state;
  logic [31:0]   pc, kill_pc;
  entry_t        mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] cnt, cnt_next;

  logic          pred_taken, accept, bypass, push, pop;
  logic [31:0]   next_pc, rd_pc;
  entry_t        fetch_ent, head_ent;

  assign pred_taken = bp_br_en && btb_hit;
  assign next_pc    = pred_taken ? bp_target : pc + 32'd4;
  assign rd_pc      = {redirect_pc[31:2], 2'b00};

  always_comb begin
    fetch_ent        = '0;
    fetch_ent.pc     = pc;
    fetch_ent.instr  = icache_rdata;
    fetch_ent.taken  = pred_taken;
    fetch_ent.target = bp_target;
    fetch_ent.meta   = bp_meta;
  end

  // Responses only count in RUN; KILL discards them and FULL has no read out.
  assign accept = (state == RUN) && icache_resp && !redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = accept && (cnt == '0) && deq_ready;
`else
  assign bypass = 1'b0;
`endif
  assign push     = accept && !bypass;
  assign pop      = deq_ready && (cnt != '0) && !redirect_valid;
  assign cnt_next = cnt + CW'(push) - CW'(pop);

  assign icache_read = !rst && (state != FULL);
  assign icache_addr = pc;
  assign count       = cnt;

  assign head_ent        = bypass ? fetch_ent : mem[head];
  assign deq_valid       = !redirect_valid && ((cnt != '0) || bypass);
  assign deq_pc          = head_ent.pc;
  assign deq_instr       = head_ent.instr;
  assign deq_pred_taken  = head_ent.taken;
  assign deq_pred_target = head_ent.target;
  assign deq_meta        = head_ent.meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      pc      <= RESET_PC;
      kill_pc <= '0;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= fetch_ent;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      cnt <= cnt_next;
      if (redirect_valid) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end

      case (state)
        RUN: begin
          if (redirect_valid) begin
            // A read is always in flight in RUN; without a response it must be drained.
            if (icache_resp) pc <= rd_pc;
            else begin
              kill_pc <= rd_pc;
              state   <= KILL;
            end
          end else begin
            if (icache_resp) pc <= next_pc;
            state <= (cnt_next == CW'(DEPTH)) ? FULL : RUN;
          end
        end
        FULL: begin
          if (redirect_valid) begin
            pc    <= rd_pc;
            state <= RUN;
          end else begin
            state <= (cnt_next == CW'(DEPTH)) ? FULL : RUN;
          end
        end
        KILL: begin
          if (redirect_valid) begin
            if (icache_resp) begin
              pc    <= rd_pc;
              state <= RUN;
            end else kill_pc <= rd_pc;
          end else if (icache_resp) begin
            pc    <= kill_pc;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;
  localparam int DEPTH  = 4;
  localparam int META_W = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0060;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0, rst = 1'b1;
  logic              icache_read, icache_resp, bp_br_en, btb_hit, redirect_valid;
  logic [31:0]       icache_addr, icache_rdata, bp_target, redirect_pc;
  logic [META_W-1:0] bp_meta, deq_meta;
  logic              deq_valid, deq_ready, deq_pred_taken;
  logic [31:0]       deq_pc, deq_instr, deq_pred_target;
  logic [$clog2(DEPTH):0] count;

  fetch_queue_unit #(.DEPTH(DEPTH), .META_W(META_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_addr(icache_addr),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .bp_br_en(bp_br_en), .btb_hit(btb_hit), .bp_target(bp_target), .bp_meta(bp_meta),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_instr(deq_instr),
    .deq_pred_taken(deq_pred_taken), .deq_pred_target(deq_pred_target),
    .deq_meta(deq_meta), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       pc, instr, target;
    logic              taken;
    logic [META_W-1:0] meta;
  } ent_t;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  ent_t        q[$];
  logic [31:0] m_pc = RESET_PC;
  bit          m_kill = 0;
  logic [31:0] m_kill_pc = '0;

  task automatic cycle(input int p_ready, input int p_resp, input int p_redir, input int p_taken);
    bit   exp_read, byp, exp_valid, taken, pop;
    ent_t cur, head;
    logic [31:0] rpc;
    @(negedge clk);
    exp_read       = m_kill || (q.size() < DEPTH);
    deq_ready      = ($urandom_range(99) < p_ready);
    icache_resp    = exp_read && ($urandom_range(99) < p_resp);
    icache_rdata   = $urandom();
    bp_br_en       = ($urandom_range(99) < p_taken);
    btb_hit        = ($urandom_range(99) < 70);
    bp_target      = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'h0000_FFFC);
    bp_meta        = META_W'($urandom());
    redirect_valid = ($urandom_range(99) < p_redir);
    rpc            = $urandom();
    if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF8 | (rpc & 32'h7);
    redirect_pc    = rpc;
    #1;
    taken     = bp_br_en && btb_hit;
    cur       = '{pc: m_pc, instr: icache_rdata, target: bp_target, taken: taken, meta: bp_meta};
    byp       = BYP && !m_kill && exp_read && icache_resp && !redirect_valid && q.size() == 0 && deq_ready;
    exp_valid = !redirect_valid && (q.size() > 0 || byp);

    chk("icache_read", 64'(icache_read), 64'(exp_read));
    if (exp_read) chk("icache_addr", 64'(icache_addr), 64'(m_pc));
    chk("count", 64'(count), 64'(q.size()));
    chk("deq_valid", 64'(deq_valid), 64'(exp_valid));
    if (exp_valid) begin
      head = (q.size() > 0) ? q[0] : cur;
      chk("deq_pc", 64'(deq_pc), 64'(head.pc));
      chk("deq_instr", 64'(deq_instr), 64'(head.instr));
      chk("deq_pred_taken", 64'(deq_pred_taken), 64'(head.taken));
      chk("deq_pred_target", 64'(deq_pred_target), 64'(head.target));
      chk("deq_meta", 64'(deq_meta), 64'(head.meta));
    end

    rpc = {redirect_pc[31:2], 2'b00};
    if (redirect_valid) begin
      q.delete();
      if (!exp_read || icache_resp) begin
        m_pc   = rpc;
        m_kill = 0;
      end else begin
        m_kill    = 1;
        m_kill_pc = rpc;
      end
    end else if (m_kill) begin
      if (icache_resp) begin
        m_pc   = m_kill_pc;
        m_kill = 0;
      end
    end else begin
      pop = deq_ready && q.size() > 0;
      if (pop) void'(q.pop_front());
      if (exp_read && icache_resp) begin
        if (!byp) q.push_back(cur);
        m_pc = taken ? bp_target : m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    icache_resp = 0; icache_rdata = '0; bp_br_en = 0; btb_hit = 0; bp_target = '0;
    bp_meta = '0; redirect_valid = 0; redirect_pc = '0; deq_ready = 0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("rst_read", 64'(icache_read), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(deq_valid), 64'd0);
    chk("rst_deq_pc", 64'(deq_pc), 64'd0);
    chk("rst_deq_instr", 64'(deq_instr), 64'd0);
    rst = 0;
    #1;
    chk("first_read", 64'(icache_read), 64'd1);
    chk("first_addr", 64'(icache_addr), 64'(RESET_PC));

    // Straight-line hits, decode always ready, no prediction.
    for (int i = 0; i < 40; i++) cycle(100, 100, 0, 0);
    // Decode stalled: queue fills and fetch stops.
    for (int i = 0; i < 40; i++) cycle(10, 90, 0, 30);
    // Mixed traffic with predictions, misses and redirects.
    for (int i = 0; i < 1500; i++) cycle(60, 50, 6, 40);
    // Long misses with frequent redirects to exercise the kill path.
    for (int i = 0; i < 600; i++) cycle(50, 15, 15, 40);
    // Back-pressure heavy with redirects.
    for (int i = 0; i < 600; i++) cycle(20, 80, 4, 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end that owns the fetch PC, drives the icache read port, applies branch-predictor redirection, and buffers fetched instructions in a DEPTH-entry queue. Decode consumes entries through a valid/ready handshake, so icache misses and decode stalls are decoupled. It replaces the fixed single-register PC/IF-ID arrangement in the pipelined datapath. It sits between the icache and the ID stage. Redirects from EX/MEM (mispredict, jal, jalr) enter through one port.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- META_W, 16, width of opaque predictor metadata carried with each entry (pbp y_out, etc.)
- RESET_PC, 32'h0000_0060, fetch address after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- icache_read  out  1  fetch request
- icache_addr  out  32  fetch address (= internal fetch PC)
- icache_rdata  in  32  instruction word
- icache_resp  in  1  response; may arrive in the same cycle as the request
- bp_br_en  in  1  predictor taken, for icache_addr (combinational lookup)
- btb_hit  in  1  BTB hit, for icache_addr
- bp_target  in  32  predicted target
- bp_meta  in  META_W  predictor metadata for icache_addr
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  restart address; bits [1:0] forced to 0
- deq_valid  out  1  head entry available
- deq_ready  in  1  decode accepts head
- deq_pc, deq_instr  out  32 each  head PC / instruction
- deq_pred_taken  out  1  head was predicted taken (bp_br_en && btb_hit)
- deq_pred_target  out  32  head predicted target
- deq_meta  out  META_W  head metadata
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- FSM states: RUN, FULL, KILL.
- RUN: icache_read=1, addr=PC.
  - On icache_resp: push {PC, rdata, bp_br_en&&btb_hit, bp_target, bp_meta}.
  - PC ← bp_target if (bp_br_en && btb_hit), else PC+4.
  - PC arithmetic is mod 2^32; 32'hFFFF_FFFC+4 → 0.
- FULL: entered when count==DEPTH after the cycle's push/pop. icache_read=0. PC holds. Returns to RUN the cycle after count<DEPTH.
- icache_addr stays stable while icache_read=1 and no response has arrived.
- redirect_valid, any state:
  - Queue flushes: count→0, head/tail pointers→0.
  - deq_valid forced 0 in that cycle; a deq_ready in that cycle pops nothing.
- Redirect with a read outstanding and no resp this cycle:
  - Latch redirect_pc; enter KILL.
  - KILL keeps icache_read=1 with the old address, then discards the response.
  - The cycle after that response: PC ← latched address, state → RUN.
- Redirect in the same cycle as icache_resp: response discarded; PC ← redirect_pc; RUN.
- Redirect while in KILL: latched address is overwritten by the newest redirect_pc.
- Redirect while in FULL, or in RUN with no read pending: PC ← redirect_pc; RUN.
- Simultaneous push and pop: count unchanged, both take effect.
- Pop is not allowed when count==0 (bypass path excepted).
- Queue is circular; pointers wrap at DEPTH.

## Timing
- Reset values:
  - PC=RESET_PC; state RUN; count=0; pointers 0.
  - icache_read=0 during the reset cycle.
  - deq_valid=0; deq_* data 0 (entry storage cleared).
- First cycle after reset: icache_read=1, icache_addr=RESET_PC.
- Latency, icache_resp at cycle N:
  - Entry visible (deq_valid=1) at N+1.
  - Next fetch address presented at N+1.
- Throughput: one instruction/cycle on hits.
- FULL is detected from end-of-cycle count, so no response is ever dropped for lack of space.
- At most one read is outstanding.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - Condition: count==0, icache_resp=1, no redirect, and deq_ready=1.
  - The response is presented on deq_* in the same cycle (deq_valid=1) and is not stored.
  - Zero-cycle fetch-to-decode latency.
- Undefined: every response is stored first; minimum latency 1 cycle.

## Test plan
- Reset, hit every cycle, deq_ready=1, no prediction → icache_addr 0x60, 0x64, 0x68 on consecutive cycles; deq_pc sequence matches one cycle later; count stays ≤1.
- deq_ready=0, DEPTH=4, hits → four pushes, count=4, icache_read drops to 0 and addr stays 0x70. deq_ready=1 for one cycle → count=3, icache_read=1 next cycle.
- bp_br_en=1, btb_hit=1, bp_target=0x200 at addr 0x64 → next fetch 0x200. Entry 0x64 has deq_pred_taken=1, deq_pred_target=0x200. With btb_hit=0, fetch goes to 0x68.
- Miss at 0x80 (resp delayed 5 cycles); redirect_pc=0x403 at cycle 2 → addr stays 0x80 until resp, response not enqueued, next addr 0x400, count=0 from cycle 3.
- Redirect in the same cycle as a push and a pop with count=2 → count=0, deq_valid=0 that cycle, next addr = redirect_pc.
- With FETCH_QUEUE_BYPASS_EN: empty queue, resp rdata=0x00000013 at 0x60, deq_ready=1 → deq_valid=1 and deq_instr=0x13 in the same cycle, count remains 0.
